instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Fetch/decode/execute controller that sequences the program-counter/ROM block and the 8-operation ALU. It issues one `pc_ena` pulse per completed instruction and latches the 8-bit instruction (opcode `[7:5]`, operand `[3:0]`). It launches the ALU through a start/done handshake and writes results back to an accumulator or a compare flag. It sits between the PC and the ALU at the top level and replaces the free-running `ena` tie-off on the PC.

## Interface
Parameters:
- `ACC_W`, default 8: accumulator and ALU operand/result width.
- `TIMEOUT`, default 15: maximum EXEC cycles waiting for `alu_done` before abort.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high.
- `ena`, in, 1: run enable.
- `mode_single`, in, 1: single-step mode.
- `step`, in, 1: single-step trigger; sampled only in IDLE.
- `instr_in`, in, 8: instruction from PC/ROM.
- `pc_ena`, out, 1: PC advance pulse.
- `alu_start`, out, 1: one-cycle ALU launch.
- `alu_opcode`, out, 3: operation select.
- `alu_a`, out, ACC_W: accumulator operand.
- `alu_b`, out, ACC_W: zero-extended immediate `instr[3:0]`.
- `alu_done`, in, 1: ALU result valid.
- `alu_result`, in, ACC_W: ALU result.
- `acc_out`, out, ACC_W: accumulator.
- `cmp_flag`, out, 1: last compare result.
- `busy`, out, 1: state ≠ IDLE.
- `error`, out, 1: sticky ALU timeout.
- `instr_count`, out, 8: retired instruction counter.
- `state_out`, out, 3: current state encoding.

## Operation
States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4. Codes 5–7 are illegal and go to IDLE.

- **IDLE**
  - Go to FETCH if `ena && (!mode_single || step)`.
  - If `error`=1, stay in IDLE until reset.
- **FETCH**
  - Latch `instr_in` into IR.
  - Go to DECODE.
- **DECODE**
  - Drive `alu_opcode`=IR[7:5], `alu_a`=acc, `alu_b`={0, IR[3:0]}. These are registered and held through WB.
  - IR[4] is reserved and ignored.
  - Go to EXEC.
- **EXEC**
  - `alu_start`=1 in the first EXEC cycle only.
  - If `alu_done`=1 in any EXEC cycle, including the first, go to WB.
  - Wait counter runs 1..TIMEOUT. If the counter reaches TIMEOUT with no `alu_done`: set `error`, go to IDLE, no writeback, no `pc_ena`.
- **WB**
  - Opcodes 0–4 (ADD/SUB/MUL/DIV/MOD): acc ← `alu_result`.
  - Opcodes 5–7 (CMP/GT/LT): `cmp_flag` ← `alu_result[0]`; acc unchanged.
  - `pc_ena`=1 for this cycle only.
  - `instr_count`+1, wrapping 255→0.
  - Next state is FETCH if `ena && !mode_single`, otherwise IDLE.

Boundary conditions:
- `ena` dropped mid-instruction: the current instruction completes through WB, then IDLE.
- `step` held high in single-step mode: exactly one instruction per IDLE entry. IDLE→FETCH needs `step` sampled in IDLE, and each pass returns to IDLE.
- `alu_done` outside EXEC: ignored.
- PC wrap (instruction 3→0): transparent to this block.
- Reset mid-operation: takes effect on the next edge from any state. All state and outputs clear. No `pc_ena` is issued.

## Timing
- Reset values: state IDLE; `pc_ena`, `alu_start`, `busy`, `error`, `cmp_flag` all 0; `acc_out`, `instr_count`, `alu_opcode`, `alu_a`, `alu_b` all 0.
- All outputs are registered except `busy` and `state_out`, which are decoded from the state register.
- Instruction latency is 3 + N cycles (FETCH, DECODE, N EXEC, WB), where N ≥ 1 is the EXEC-cycle index at which `alu_done` is seen. The minimum is 4 cycles per instruction.
- `acc_out`/`cmp_flag` update on the edge ending WB, coincident with the PC increment.
- `instr_in` must be stable by the FETCH cycle, one edge after the `pc_ena` edge. The PC/ROM satisfies this.

## Structure
- Shared package `jsilicon_pkg`:
  - opcode constants OP_ADD..OP_LT (0..7);
  - state encodings ST_IDLE..ST_WB;
  - field positions OPC_MSB=7, OPC_LSB=5, IMM_MSB=3.
- One sub-module, `alu_wait_timer`: EXEC wait counter with load/clear and `expired` output.
- Everything else stays in the top-level FSM.

## Test plan
- **Free run.** `ena`=1, mode_single=0, ALU model done in first EXEC cycle, instr_in=8'b000_0_0011 (ADD 3) constant, ALU returns a+b.
  - `pc_ena` pulses every 4 cycles.
  - acc = 3, 6, 9, 12 after 4 instructions; `instr_count`=4.
- **Compare.** acc=5, instr 8'b101_0_0101 (CMP 5), ALU returns 1.
  - `cmp_flag`=1, acc stays 5.
  - Then GT 9 returning 0 gives `cmp_flag`=0.
- **Single step.** mode_single=1, three `step` pulses 20 cycles apart.
  - Exactly 3 `pc_ena` pulses and `instr_count`=3.
  - `busy` is low between steps.
- **ALU latency and timeout.**
  - `alu_done` after 3 EXEC cycles: instruction takes 6 cycles.
  - `alu_done` never asserted: `error`=1 after 15 EXEC cycles, state IDLE, no `pc_ena`, acc unchanged.
  - FSM stays IDLE with `ena`=1 until reset.
- **Mid-operation events.**
  - `ena` dropped during DECODE: WB still occurs, then IDLE.
  - `reset` asserted in EXEC: next cycle state=0, acc=0, `instr_count`=0, `pc_ena`=0.
- **Counter wrap.** 256 instructions in free run: `instr_count` returns to 0 and operation continues uninterrupted.

Source files
------------

// File: rtl/jsilicon_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM state codes
// and instruction field positions.
package jsilicon_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;
    localparam logic [2:0] OP_GT  = 3'd6;
    localparam logic [2:0] OP_LT  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int IMM_MSB = 3;

    // Compare-class opcodes update the flag instead of the accumulator.
    function automatic logic is_cmp_op(input logic [2:0] op);
        return op >= OP_CMP;
    endfunction

endpackage

// File: rtl/instr_sequencer_timer.sv
// EXEC wait counter: loaded to 1 on entry to EXEC, counts up to TIMEOUT and
// flags expiry so the sequencer can abort a hung ALU operation.
module alu_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CNT_W'(1);
        end else if (clear) begin
            count_reg <= '0;
        end else if (!expired) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = (count_reg == CNT_W'(TIMEOUT));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller between the PC/ROM and the ALU: one PC
// advance per retired instruction, ALU start/done handshake, accumulator writeback.
module instr_sequencer
    import jsilicon_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic             mode_single,
    input  logic             step,
    input  logic [7:0]       instr_in,
    output logic             pc_ena,
    output logic             alu_start,
    output logic [2:0]       alu_opcode,
    output logic [ACC_W-1:0] alu_a,
    output logic [ACC_W-1:0] alu_b,
    input  logic             alu_done,
    input  logic [ACC_W-1:0] alu_result,
    output logic [ACC_W-1:0] acc_out,
    output logic             cmp_flag,
    output logic             busy,
    output logic             error,
    output logic [7:0]       instr_count,
    output logic [2:0]       state_out
);

    state_t           state_reg, state_next;
    logic [7:0]       ir_reg;
    logic             pc_ena_reg, alu_start_reg, error_reg, cmp_reg;
    logic [2:0]       alu_opcode_reg;
    logic [ACC_W-1:0] alu_a_reg, alu_b_reg, result_reg, acc_reg;
    logic [7:0]       count_reg;
    logic             expired, timeout;
    logic             unused_rsv;

    // Bit 4 of the instruction is reserved and deliberately has no effect.
    assign unused_rsv = ir_reg[4];

    alu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (state_reg == ST_DECODE),
        .clear   (state_reg != ST_EXEC),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        case (state_reg)
            ST_IDLE:   if (!error_reg && ena && (!mode_single || step)) state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if (alu_done) begin
                    state_next = ST_WB;
                end else if (expired) begin
                    state_next = ST_IDLE;
                    timeout    = 1'b1;
                end
            end
            ST_WB:     state_next = (ena && !mode_single) ? ST_FETCH : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ir_reg         <= '0;
            pc_ena_reg     <= 1'b0;
            alu_start_reg  <= 1'b0;
            alu_opcode_reg <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            result_reg     <= '0;
            acc_reg        <= '0;
            cmp_reg        <= 1'b0;
            error_reg      <= 1'b0;
            count_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            alu_start_reg <= (state_reg == ST_DECODE);
            pc_ena_reg    <= (state_reg == ST_EXEC) && alu_done;
            if (state_reg == ST_FETCH) begin
                ir_reg <= instr_in;
            end
            if (state_reg == ST_DECODE) begin
                alu_opcode_reg <= ir_reg[OPC_MSB:OPC_LSB];
                alu_a_reg      <= acc_reg;
                alu_b_reg      <= ACC_W'(ir_reg[IMM_MSB:0]);
            end
            // Capture the result so writeback does not depend on the ALU holding it.
            if ((state_reg == ST_EXEC) && alu_done) begin
                result_reg <= alu_result;
            end
            if (timeout) begin
                error_reg <= 1'b1;
            end
            if (state_reg == ST_WB) begin
                if (is_cmp_op(alu_opcode_reg)) begin
                    cmp_reg <= result_reg[0];
                end else begin
                    acc_reg <= result_reg;
                end
                count_reg <= count_reg + 8'd1;
            end
        end
    end

    assign pc_ena      = pc_ena_reg;
    assign alu_start   = alu_start_reg;
    assign alu_opcode  = alu_opcode_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign acc_out     = acc_reg;
    assign cmp_flag    = cmp_reg;
    assign error       = error_reg;
    assign instr_count = count_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign state_out   = state_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_instr_sequencer;
    import jsilicon_pkg::*;

    logic       clock, reset, ena, mode_single, step;
    logic [7:0] instr_in;
    logic       pc_ena, alu_start;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a, alu_b;
    logic       alu_done;
    logic [7:0] alu_result, acc_out;
    logic       cmp_flag, busy, error;
    logic [7:0] instr_count;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_fail   = 0;
    int alu_lat  = 1;   // EXEC cycle index at which the ALU answers; 0 = never
    int exec_idx = 0;

    // Reference model: architectural state after each retired instruction.
    bit [7:0] m_acc, m_cnt;
    bit       m_cmp;

    instr_sequencer #(.ACC_W(8), .TIMEOUT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .ena         (ena),
        .mode_single (mode_single),
        .step        (step),
        .instr_in    (instr_in),
        .pc_ena      (pc_ena),
        .alu_start   (alu_start),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .acc_out     (acc_out),
        .cmp_flag    (cmp_flag),
        .busy        (busy),
        .error       (error),
        .instr_count (instr_count),
        .state_out   (state_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 8'hFF : a / b;
            OP_MOD:  return (b == 0) ? a : a % b;
            OP_CMP:  return {7'd0, a == b};
            OP_GT:   return {7'd0, a > b};
            default: return {7'd0, a < b};
        endcase
    endfunction

    // ALU environment: answers alu_lat EXEC cycles after alu_start, for one cycle.
    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset || alu_done) begin
                alu_done = 1'b0;
                exec_idx = 0;
            end else if (alu_start) begin
                exec_idx = 1;
            end else if (exec_idx != 0) begin
                exec_idx++;
            end
            if (exec_idx != 0 && exec_idx == alu_lat) begin
                alu_done   = 1'b1;
                alu_result = alu_fn(alu_opcode, alu_a, alu_b);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, "_acc"}, 32'(acc_out), 32'(m_acc));
        chk({tag, "_cmp"}, 32'(cmp_flag), 32'(m_cmp));
        chk({tag, "_cnt"}, 32'(instr_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_cmp = 0;
        m_cnt = 0;
    endtask

    task automatic model_retire(input logic [2:0] op, input logic [3:0] imm);
        logic [7:0] r;
        r = alu_fn(op, m_acc, {4'd0, imm});
        if (op >= OP_CMP) m_cmp = r[0];
        else              m_acc = r;
        m_cnt = m_cnt + 8'd1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Called in IDLE (with ena set) or in the WB cycle of the previous instruction.
    task automatic run_instr(input logic [2:0] op, input logic rsv, input logic [3:0] imm, input int lat);
        int n;
        instr_in = {op, rsv, imm};
        alu_lat  = lat;
        n        = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk_arch("prev");
        end while (!pc_ena && n < 40);
        chk("pc_ena", 32'(pc_ena), 1);
        chk("period", n, 3 + lat);
        chk("alu_opcode", 32'(alu_opcode), 32'(op));
        chk("alu_a", 32'(alu_a), 32'(m_acc));
        chk("alu_b", 32'(alu_b), 32'(imm));
        model_retire(op, imm);
        $display("instr op=%0d imm=%0d lat=%0d cycles=%0d acc_exp=%0d cmp_exp=%0d cnt_exp=%0d",
                 op, imm, lat, n, m_acc, m_cmp, m_cnt);
    endtask

    // Called in a WB cycle: drop ena so the FSM parks in IDLE.
    task automatic stop_run();
        ena = 1'b0;
        tick();
        chk_arch("stop");
        chk("stop_state", 32'(state_out), 0);
    endtask

    initial begin
        int n, pcs;
        reset       = 1'b1;
        ena         = 1'b0;
        mode_single = 1'b0;
        step        = 1'b0;
        instr_in    = '0;
        model_reset();
        tick();
        tick();
        chk("rst_state", 32'(state_out), 0);
        chk("rst_pc_ena", 32'(pc_ena), 0);
        chk("rst_alu_start", 32'(alu_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_cmp", 32'(cmp_flag), 0);
        chk("rst_acc", 32'(acc_out), 0);
        chk("rst_cnt", 32'(instr_count), 0);
        chk("rst_opcode", 32'(alu_opcode), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        reset = 1'b0;

        // Free run: ADD 3 four times
        ena = 1'b1;
        repeat (4) run_instr(OP_ADD, 1'b0, 4'd3, 1);
        stop_run();
        chk("free_acc", 32'(acc_out), 12);
        chk("free_cnt", 32'(instr_count), 4);

        // Compare: bring acc to 5, CMP 5 then GT 9
        ena = 1'b1;
        run_instr(OP_SUB, 1'b0, 4'd7, 1);
        run_instr(OP_CMP, 1'b0, 4'd5, 1);
        run_instr(OP_GT, 1'b0, 4'd9, 1);
        stop_run();
        chk("cmp_acc", 32'(acc_out), 5);
        chk("cmp_flag_gt", 32'(cmp_flag), 0);

        // Single step: three step pulses 20 cycles apart
        apply_reset();
        mode_single = 1'b1;
        ena         = 1'b1;
        instr_in    = {OP_ADD, 1'b0, 4'd1};
        alu_lat     = 1;
        pcs         = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (19) begin
                tick();
                if (pc_ena) begin
                    pcs++;
                    model_retire(OP_ADD, 4'd1);
                end
            end
            chk("ss_busy_gap", 32'(busy), 0);
            chk_arch("ss");
            $display("step %0d pulses=%0d acc=%0d", k, pcs, acc_out);
        end
        chk("ss_pulses", pcs, 3);
        chk("ss_cnt", 32'(instr_count), 3);
        mode_single = 1'b0;

        // ALU latency
        ena = 1'b1;
        run_instr(OP_ADD, 1'b0, 4'd2, 3);
        run_instr(OP_MUL, 1'b1, 4'd3, 2);
        stop_run();

        // Timeout: ALU never answers
        alu_lat  = 0;
        instr_in = {OP_ADD, 1'b0, 4'd5};
        ena      = 1'b1;
        n        = 0;
        pcs      = 0;
        do begin
            tick();
            n++;
            if (pc_ena) pcs++;
        end while (!error && n < 40);
        chk("to_cycles", n, 18);
        chk("to_pc_ena", pcs, 0);
        chk("to_state", 32'(state_out), 0);
        chk_arch("to");
        repeat (10) tick();
        chk("to_hold_state", 32'(state_out), 0);
        chk("to_hold_error", 32'(error), 1);
        $display("timeout cycles=%0d error=%0d", n, error);
        apply_reset();
        chk("to_rst_error", 32'(error), 0);

        // ena dropped during DECODE
        alu_lat  = 1;
        instr_in = {OP_ADD, 1'b0, 4'd4};
        ena      = 1'b1;
        tick();
        tick();
        ena = 1'b0;
        n   = 2;
        while (!pc_ena && n < 40) begin
            tick();
            n++;
        end
        chk("drop_wb", n, 4);
        model_retire(OP_ADD, 4'd4);
        tick();
        chk("drop_idle", 32'(state_out), 0);
        chk_arch("drop");
        $display("ena drop wb_at=%0d acc=%0d", n, acc_out);

        // reset asserted in EXEC
        alu_lat  = 10;
        instr_in = {OP_ADD, 1'b0, 4'd6};
        ena      = 1'b1;
        tick();
        tick();
        tick();
        chk("rx_in_exec", 32'(state_out), 3);
        tick();
        reset = 1'b1;
        tick();
        chk("rx_state", 32'(state_out), 0);
        chk("rx_acc", 32'(acc_out), 0);
        chk("rx_cnt", 32'(instr_count), 0);
        chk("rx_pc_ena", 32'(pc_ena), 0);
        chk("rx_busy", 32'(busy), 0);
        ena = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();

        // Random instruction stream in free run
        ena = 1'b1;
        repeat (24) begin
            run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
        end
        stop_run();

        // Counter wrap: 256 back-to-back instructions, then keep going
        apply_reset();
        ena = 1'b1;
        for (int i = 0; i < 258; i++) run_instr(OP_ADD, 1'b0, 4'd1, 1);
        stop_run();
        chk("wrap_cnt", 32'(instr_count), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
